// File: rtl/udc_pkg.sv
// Shared types for the up/down count sequencer: counting modes and FSM states.
package udc_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    UP_WRAP    = 2'd0,
    DOWN_WRAP  = 2'd1,
    BOUNCE     = 2'd2,
    ONESHOT_UP = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  // Direction a mode starts (or steps) in when leaving IDLE.
  function automatic logic mode_counts_up(mode_t m);
    return m != DOWN_WRAP;
  endfunction

endpackage

// File: rtl/updown_count_sched_if.sv
// Configuration valid/ready bus: mode plus lower/upper count bounds.
interface updown_count_sched_if #(
  parameter int WIDTH = 5
);

  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [udc_pkg::MODE_W-1:0] cfg_mode;
  logic [WIDTH-1:0]          cfg_lo;
  logic [WIDTH-1:0]          cfg_hi;

  modport master (
    output cfg_valid, cfg_mode, cfg_lo, cfg_hi,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_lo, cfg_hi,
    output cfg_ready
  );

endinterface

// File: rtl/udc_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the last cycle as tick.
module udc_tick_gen #(
  parameter int DIV   = 25000000,
  parameter int DIV_W = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/updown_count_sched.sv
// Single-clock up/down count sequencer with bounded wrap/bounce/one-shot modes.
// Optional UDC_STEP_EN adds a step input that advances count by one while idle.
module updown_count_sched
  import udc_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DIV   = 25000000,
  parameter int DIV_W = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_count_sched_if.slave  cfg,
  input  logic                 start,
  input  logic                 stop,
`ifdef UDC_STEP_EN
  input  logic                 step,
`endif
  output logic [WIDTH-1:0]     count,
  output logic                 dir,
  output logic                 busy,
  output logic                 wrap,
  output logic                 done,
  output logic                 cfg_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             done;
    logic             turn;
  } adv_t;

  // One position of movement, applying the bound rules of the mode.
  function automatic adv_t advance(logic up, mode_t m, logic [WIDTH-1:0] c,
                                   logic [WIDTH-1:0] lo_v, logic [WIDTH-1:0] hi_v);
    adv_t r;
    r.count = c;
    r.wrap  = 1'b0;
    r.done  = 1'b0;
    r.turn  = 1'b0;
    if (up) begin
      if (c < hi_v) begin
        r.count = c + ONE;
      end else begin
        case (m)
          BOUNCE: begin
            r.turn  = 1'b1;
            r.wrap  = 1'b1;
            r.count = (lo_v == hi_v) ? hi_v : hi_v - ONE;
          end
          ONESHOT_UP: r.done = 1'b1;
          default: begin
            r.count = lo_v;
            r.wrap  = 1'b1;
          end
        endcase
      end
    end else begin
      if (c > lo_v) begin
        r.count = c - ONE;
      end else if (m == BOUNCE) begin
        r.turn  = 1'b1;
        r.wrap  = 1'b1;
        r.count = (lo_v == hi_v) ? lo_v : lo_v + ONE;
      end else begin
        r.count = hi_v;
        r.wrap  = 1'b1;
      end
    end
    return r;
  endfunction

  state_t           state, state_nxt;
  mode_t            mode, mode_nxt;
  logic [WIDTH-1:0] lo, lo_nxt;
  logic [WIDTH-1:0] hi, hi_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             err_nxt, wrap_nxt, done_nxt;
  logic             tick, adv_up;
  adv_t             adv;
  mode_t            cfg_mode_e;

  assign busy          = (state != IDLE);
  assign dir           = (state == UP);
  assign cfg.cfg_ready = (state == IDLE);
  assign cfg_mode_e    = mode_t'(cfg.cfg_mode);

  udc_tick_gen #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (!busy || stop),
    .tick (tick)
  );

  // Idle stepping follows the mode's starting direction; running follows state.
  assign adv_up = (state == IDLE) ? mode_counts_up(mode) : (state == UP);
  assign adv    = advance(adv_up, mode, count, lo, hi);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path infers a latch.
    state_nxt = state;
    mode_nxt  = mode;
    lo_nxt    = lo;
    hi_nxt    = hi;
    count_nxt = count;
    err_nxt   = cfg_err;
    wrap_nxt  = 1'b0;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (cfg.cfg_valid) begin
          if (cfg.cfg_lo <= cfg.cfg_hi) begin
            mode_nxt  = cfg_mode_e;
            lo_nxt    = cfg.cfg_lo;
            hi_nxt    = cfg.cfg_hi;
            err_nxt   = 1'b0;
            count_nxt = (cfg_mode_e == DOWN_WRAP) ? cfg.cfg_hi : cfg.cfg_lo;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (start && !stop) begin
          state_nxt = mode_counts_up(mode) ? UP : DOWN;
        end
`ifdef UDC_STEP_EN
        else if (step && !start) begin
          count_nxt = adv.count;
          wrap_nxt  = adv.wrap;
          done_nxt  = adv.done;
        end
`endif
      end

      UP, DOWN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (tick) begin
          count_nxt = adv.count;
          wrap_nxt  = adv.wrap;
          done_nxt  = adv.done;
          if (adv.done) begin
            state_nxt = IDLE;
          end else if (adv.turn) begin
            state_nxt = (state == UP) ? DOWN : UP;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mode    <= UP_WRAP;
      lo      <= '0;
      hi      <= '1;
      count   <= '0;
      cfg_err <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state   <= state_nxt;
      mode    <= mode_nxt;
      lo      <= lo_nxt;
      hi      <= hi_nxt;
      count   <= count_nxt;
      cfg_err <= err_nxt;
      wrap    <= wrap_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_updown_count_sched.sv
// Scoreboard bench for updown_count_sched with DIV=4, WIDTH=5.
module tb_updown_count_sched;
  import udc_pkg::*;

  localparam int WIDTH = 5;
  localparam int DIV   = 4;
  localparam int DIV_W = 3;

  logic             clk   = 1'b0;
  logic             rst   = 1'b0;
  logic             start = 1'b0;
  logic             stop  = 1'b0;
`ifdef UDC_STEP_EN
  logic             step  = 1'b0;
`endif
  logic [WIDTH-1:0] count;
  logic             dir, busy, wrap, done, cfg_err;

  updown_count_sched_if #(.WIDTH(WIDTH)) cfg_bus ();

  updown_count_sched #(
    .WIDTH (WIDTH),
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg_bus),
    .start   (start),
    .stop    (stop),
`ifdef UDC_STEP_EN
    .step    (step),
`endif
    .count   (count),
    .dir     (dir),
    .busy    (busy),
    .wrap    (wrap),
    .done    (done),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             done;
    logic             dir;
    logic             busy;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_ev(input logic [WIDTH-1:0] c, input logic w, input logic d,
                         input logic dr, input logic b);
    ev_t e;
    e.count = c;
    e.wrap  = w;
    e.done  = d;
    e.dir   = dr;
    e.busy  = b;
    exp_q.push_back(e);
  endtask

  // Any count change or wrap/done pulse is an output event matched against the queue.
  logic [WIDTH-1:0] prev_count = '0;
  always @(negedge clk) begin
    if (count !== prev_count || wrap || done) begin
      check("ev_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_count", count, e.count);
        check("ev_wrap",  wrap,  e.wrap);
        check("ev_done",  done,  e.done);
        check("ev_dir",   dir,   e.dir);
        check("ev_busy",  busy,  e.busy);
      end
    end
    prev_count = count;
  end

  task automatic do_cfg(input mode_t m, input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi,
                        input logic with_start);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_mode  = m;
    cfg_bus.cfg_lo    = lo;
    cfg_bus.cfg_hi    = hi;
    start             = with_start;
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    start             = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called right after do_start: stops after exactly k ticks.
  task automatic run_stop(input int k);
    repeat (4 * k) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_count"},   count,             0);
    check({pfx, "_dir"},     dir,               0);
    check({pfx, "_busy"},    busy,              0);
    check({pfx, "_wrap"},    wrap,              0);
    check({pfx, "_done"},    done,              0);
    check({pfx, "_cfg_err"}, cfg_err,           0);
    check({pfx, "_ready"},   cfg_bus.cfg_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_mode  = '0;
    cfg_bus.cfg_lo    = '0;
    cfg_bus.cfg_hi    = '0;

    // Reset, then default bounds: first tick 4 cycles after busy, wrap 31->0.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    for (int i = 1; i < 32; i++) push_ev(WIDTH'(i), 1'b0, 1'b0, 1'b1, 1'b1);
    push_ev(5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    do_start();
    check("busy_rise", busy, 1);
    check("dir_up", dir, 1);
    repeat (3) @(negedge clk);
    check("pre_tick_count", count, 0);
    repeat (4 * 32 - 3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_count", count, 0);

    // UP_WRAP 3..5.
    push_ev(5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cfg(UP_WRAP, 5'd3, 5'd5, 1'b0);
    check("cfg_ok_err", cfg_err, 0);
    push_ev(5'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    push_ev(5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    push_ev(5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    do_start();
    check("ready_busy", cfg_bus.cfg_ready, 0);
    run_stop(3);
    check("upwrap_end", count, 3);

    // BOUNCE 2..4.
    push_ev(5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cfg(BOUNCE, 5'd2, 5'd4, 1'b0);
    push_ev(5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    push_ev(5'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    push_ev(5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    push_ev(5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ev(5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    do_start();
    run_stop(5);
    check("bounce_end", count, 3);

    // ONESHOT_UP 0..2.
    push_ev(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cfg(ONESHOT_UP, 5'd0, 5'd2, 1'b0);
    push_ev(5'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    push_ev(5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    push_ev(5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    do_start();
    repeat (4 * 3 + 8) @(negedge clk);
    check("oneshot_busy", busy, 0);
    check("oneshot_count", count, 2);
    check("oneshot_ready", cfg_bus.cfg_ready, 1);

    // Bad config keeps ONESHOT 0..2; a start then finishes on the first tick.
    do_cfg(UP_WRAP, 5'd9, 5'd4, 1'b0);
    check("bad_cfg_err", cfg_err, 1);
    check("bad_cfg_count", count, 2);
    push_ev(5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    do_start();
    repeat (8) @(negedge clk);
    check("retained_busy", busy, 0);

    // BOUNCE lo==hi: count holds, wrap every tick.
    push_ev(5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cfg(BOUNCE, 5'd1, 5'd1, 1'b0);
    check("cfg_err_clear", cfg_err, 0);
    push_ev(5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    push_ev(5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    push_ev(5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    do_start();
    run_stop(3);
    check("flat_count", count, 1);

    // start and stop together in IDLE.
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_idle", busy, 0);

    // Stop mid-run at 7.
    push_ev(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cfg(UP_WRAP, 5'd0, 5'd31, 1'b0);
    for (int i = 1; i <= 7; i++) push_ev(WIDTH'(i), 1'b0, 1'b0, 1'b1, 1'b1);
    do_start();
    run_stop(7);
    check("midstop_count", count, 7);
    check("midstop_busy", busy, 0);
    check("midstop_dir", dir, 0);

    // Asynchronous reset mid-run.
    push_ev(5'd8, 1'b0, 1'b0, 1'b1, 1'b1);
    push_ev(5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    push_ev(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_start();
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;

    // Config with start in the same cycle: config wins; then DOWN_WRAP 4..6.
    push_ev(5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cfg(DOWN_WRAP, 5'd4, 5'd6, 1'b1);
    check("cfg_beats_start", busy, 0);
    push_ev(5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ev(5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ev(5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    do_start();
    check("down_busy", busy, 1);
    check("down_dir", dir, 0);
    run_stop(3);
    check("downwrap_end", count, 6);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
